alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares one ALU instance between two requesters:
  - Port 0: core execute stage.
  - Port 1: auxiliary requester (address generation / debug).
- Round-robin arbitration with per-port valid/ready request and response handshakes.
- Latched operands, registered result and flags.
- Sits between the decode/execute control and the shared ALU, and is the only driver of the ALU's operand, `fop`, `alu_mux_en` and `u` inputs.

## Interface
- `RESET_PRIO`, default 0: port holding priority after reset (0 or 1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- Each of the following port signals exists twice, once with N=0 and once with N=1 (`r0_*`, `r1_*`):
  - `rN_req_valid` in 1: request present.
  - `rN_req_ready` out 1: request accepted this cycle when high together with `rN_req_valid`.
  - `rN_rs_a` in 32: operand A, two's-complement or unsigned per `rN_uns`.
  - `rN_rs_b` in 32: operand B.
  - `rN_imm` in 32: immediate.
  - `rN_fop` in 4: ALU function code (`fop_t` encoding).
  - `rN_imm_sel` in 1: operand B taken from `rN_imm` instead of `rN_rs_b`.
  - `rN_uns` in 1: unsigned operand interpretation.
  - `rN_resp_valid` out 1: response available for port N.
  - `rN_resp_ready` in 1: port N consumes the response.
  - `rN_resp_result` out 32: ALU result.
  - `rN_resp_flags` out 3: {Z,N,V} from the ALU.
  - `rN_resp_err` out 1: `fop` outside the defined encodings (9..15).

## Operation
- **FSM `arb_state_t`: IDLE, EXEC, RESP.**
  - **IDLE:** grant computed combinationally from the valids and the priority pointer `prio`.
    - Only one port valid: that port is granted.
    - Both ports valid: port `prio` is granted.
    - Neither valid: no grant.
    - The granted port sees `req_ready`=1. On grant:
      - Latch operands, `fop`, `imm_sel`, `uns` and `owner`.
      - `prio` <= the port not granted.
      - Go to EXEC.
  - **EXEC:** latched fields drive the ALU.
    - At the cycle end, capture `result`, {Z,N,V} and `err`=(`fop`>8) into the response register.
    - Set `resp_valid` for `owner`.
    - Go to RESP.
  - **RESP:** `owner`'s `resp_valid`=1, payload held stable.
    - When the owner's `resp_ready`=1: clear `resp_valid`, go to IDLE.
    - Otherwise stay in RESP indefinitely.
- **`req_ready`:** 0 in EXEC and RESP for both ports. Never asserted for the non-granted port.
- **Response visibility:** the non-owner port's `resp_valid` is always 0. Response data outputs are shared but qualified by `resp_valid`.
- **Operand mapping to the ALU:**
  - `rs_a` → `srda` and `rda_u`; `rs_b` → `srdb` and `rdb_u`.
  - `imm` → `imm_gen`; `imm_sel` → `alu_mux_en`; `uns` → `u`.
- **Unsupported `fop`:** the ALU returns 0, so flags are Z=1, N=0, V=0, and `err`=1. No exception path.
- **Request retraction:** a requester may drop `req_valid` without handshake. Nothing is latched unless `valid`&&`ready` occurred.
- **Arithmetic:** 32-bit wrap-around; V follows the ALU's ADD/SUB signed-overflow rule and is 0 for all other functions.

## Timing
- Reset values:
  - state=IDLE, `prio`=`RESET_PRIO`, all `resp_valid`=0.
  - `resp_result`=0, `resp_flags`=0, `resp_err`=0.
  - `req_ready` forced to 0 while `rst`=1.
- Latency: request accepted at cycle 0 (IDLE) → EXEC at cycle 1 → `resp_valid` high at cycle 2.
- Throughput: if `resp_ready`=1 at cycle 2, IDLE at cycle 3 and the next accept occurs at cycle 3. Minimum issue interval is 3 cycles.
- Under continuous requests on both ports, grants strictly alternate: 0, 1, 0, … when `RESET_PRIO`=0.
- Backpressure: the response payload stays bit-stable from `resp_valid` rise until the handshake. Both ports stall (`ready`=0) meanwhile.
- Reset in EXEC or RESP: the in-flight operation is discarded with no response, and all state returns to reset values asynchronously.

## Structure
- Shared package `alu_pkg` holds:
  - `fop_t` (ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, IMM=8).
  - `arb_state_t`.
  - `alu_flags_t` packed {Z,N,V}.
  - `FOP_MAX`=8.
- One sub-module: the existing `ALU`, instantiated once inside `alu_arbiter`. No other hierarchy.

## Test plan
- **Single ADD:** r0 sends ADD, a=5, b=7 → r0 `resp_valid` at cycle 2, result=12, flags=000, err=0; r1 sees no response.
- **Simultaneous requests after reset, `RESET_PRIO`=0:** r0 ADD 1+1 and r1 XOR 0xF0^0x0F both held valid → r0 served first (2), then r1 (0xFF). Six back-to-back requests alternate 0,1,0,1,0,1.
- **Signed overflow:** r1 SUB a=0x80000000, b=1 → result 0x7FFFFFFF, flags Z=0, N=0, V=1.
- **Immediate and invalid `fop`:**
  - SLL with `imm_sel`=1, a=1, imm=4 → 16.
  - `fop`=IMM, imm=0xDEADBEEF → 0xDEADBEEF.
  - `fop`=12 → result 0, flags 100, err=1.
- **Backpressure:** r0 `resp_ready` low for 4 cycles while r1 is valid → r0 payload stable, r1 `req_ready`=0. r1 is accepted in the cycle after the r0 handshake.
- **Reset mid-operation:** `rst` asserted in EXEC → no `resp_valid` ever appears for that request. After release, the first grant follows `RESET_PRIO`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice.
//   fop_t       : ALU function encodings (9..15 are undefined and flagged as errors)
//   arb_state_t : arbiter FSM states
//   alu_flags_t : packed {Z,N,V} result flags
//   FOP_MAX     : highest defined function code
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    SLL = 4'd2,
    SRL = 4'd3,
    SRA = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    IMM = 4'd8
  } fop_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  localparam logic [3:0] FOP_MAX = 4'd8;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester port of the ALU arbiter: request handshake with operands and
// function code, response handshake with result, flags and error.
//   master : requester side (drives request fields and resp_ready)
//   slave  : arbiter side (drives req_ready and response fields)
interface alu_arbiter_if;
  import alu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] rs_a;
  logic [31:0] rs_b;
  logic [31:0] imm;
  logic [3:0]  fop;
  logic        imm_sel;
  logic        uns;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  alu_flags_t  resp_flags;
  logic        resp_err;

  modport master (
    output req_valid, rs_a, rs_b, imm, fop, imm_sel, uns, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, resp_err
  );

  modport slave (
    input  req_valid, rs_a, rs_b, imm, fop, imm_sel, uns, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags, resp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU.
//   srda/rda_u   : operand A (signed / unsigned views), picked by u
//   srdb/rdb_u   : operand B (signed / unsigned views), picked by u
//   imm_gen      : immediate, replaces operand B when alu_mux_en is set
//   fop          : function code (fop_t); undefined codes return 0
//   result/flags : 32-bit result and {Z,N,V}
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] srda,
  input  logic [31:0] rda_u,
  input  logic [31:0] srdb,
  input  logic [31:0] rdb_u,
  input  logic [31:0] imm_gen,
  input  logic [3:0]  fop,
  input  logic        alu_mux_en,
  input  logic        u,
  output logic [31:0] result,
  output alu_flags_t  flags
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf;

  always_comb begin
    op_a = u ? rda_u : srda;
    op_b = alu_mux_en ? imm_gen : (u ? rdb_u : srdb);
    sum  = op_a + op_b;
    diff = op_a - op_b;
    result = '0;
    ovf    = 1'b0;
    case (fop)
      ADD: begin
        result = sum;
        // Same-sign operands producing a different-sign sum
        ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      SUB: begin
        result = diff;
        ovf    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      SLL:     result = op_a << op_b[4:0];
      SRL:     result = op_a >> op_b[4:0];
      SRA:     result = 32'($signed(op_a) >>> op_b[4:0]);
      AND:     result = op_a & op_b;
      OR:      result = op_a | op_b;
      XOR:     result = op_a ^ op_b;
      IMM:     result = imm_gen;
      default: result = '0;
    endcase
    flags.z = (result == '0);
    flags.n = result[31];
    flags.v = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
//   clk, rst : single rising-edge clock, asynchronous active-high reset
//   r0, r1   : requester ports (r0 = core execute, r1 = auxiliary)
// One operation in flight: IDLE grants and latches, EXEC evaluates the ALU and
// registers the result, RESP holds the response until the owner accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave r0,
  alu_arbiter_if.slave r1
);

  arb_state_t  state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [3:0]  fop_q, fop_d;
  logic        imm_sel_q, imm_sel_d;
  logic        uns_q, uns_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_result_q, resp_result_d;
  alu_flags_t  resp_flags_q, resp_flags_d;
  logic        resp_err_q, resp_err_d;

  logic        gnt0;
  logic        gnt1;
  logic        owner_ready;
  logic [31:0] alu_result;
  alu_flags_t  alu_flags;

  // A lone valid wins; on contention the pointer decides.
  always_comb begin
    gnt0 = (state_q == IDLE) && r0.req_valid && (!r1.req_valid || !prio_q);
    gnt1 = (state_q == IDLE) && r1.req_valid && (!r0.req_valid || prio_q);
  end

  assign r0.req_ready = gnt0 && !rst;
  assign r1.req_ready = gnt1 && !rst;

  assign owner_ready = owner_q ? r1.resp_ready : r0.resp_ready;

  // Data outputs are shared; only the owner sees resp_valid.
  assign r0.resp_valid  = resp_valid_q && !owner_q;
  assign r1.resp_valid  = resp_valid_q && owner_q;
  assign r0.resp_result = resp_result_q;
  assign r1.resp_result = resp_result_q;
  assign r0.resp_flags  = resp_flags_q;
  assign r1.resp_flags  = resp_flags_q;
  assign r0.resp_err    = resp_err_q;
  assign r1.resp_err    = resp_err_q;

  alu_arbiter_alu u_alu (
    .srda       (a_q),
    .rda_u      (a_q),
    .srdb       (b_q),
    .rdb_u      (b_q),
    .imm_gen    (imm_q),
    .fop        (fop_q),
    .alu_mux_en (imm_sel_q),
    .u          (uns_q),
    .result     (alu_result),
    .flags      (alu_flags)
  );

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    owner_d       = owner_q;
    a_d           = a_q;
    b_d           = b_q;
    imm_d         = imm_q;
    fop_d         = fop_q;
    imm_sel_d     = imm_sel_q;
    uns_d         = uns_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d   = gnt1;
          prio_d    = gnt0;  // pointer moves to the port that lost
          a_d       = gnt1 ? r1.rs_a    : r0.rs_a;
          b_d       = gnt1 ? r1.rs_b    : r0.rs_b;
          imm_d     = gnt1 ? r1.imm     : r0.imm;
          fop_d     = gnt1 ? r1.fop     : r0.fop;
          imm_sel_d = gnt1 ? r1.imm_sel : r0.imm_sel;
          uns_d     = gnt1 ? r1.uns     : r0.uns;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        resp_result_d = alu_result;
        resp_flags_d  = alu_flags;
        resp_err_d    = (fop_q > FOP_MAX);
        resp_valid_d  = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prio_q        <= 1'(RESET_PRIO);
      owner_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      imm_q         <= '0;
      fop_q         <= '0;
      imm_sel_q     <= 1'b0;
      uns_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      a_q           <= a_d;
      b_q           <= b_d;
      imm_q         <= imm_d;
      fop_q         <= fop_d;
      imm_sel_q     <= imm_sel_d;
      uns_q         <= uns_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single operations with expected results,
// a scoreboard queue filled at request acceptance and drained by a response
// monitor, plus hand-written contention, backpressure and reset sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    bit          port;
    logic [3:0]  fop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        imm_sel;
    logic        uns;
    logic [31:0] res;
    logic [2:0]  flags;
    logic        err;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] res;
    logic [2:0]  flags;
    logic        err;
  } sb_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  sb_t  sb[$];
  vec_t vecs[15];

  alu_arbiter_if r0_if ();
  alu_arbiter_if r1_if ();

  alu_arbiter #(
    .RESET_PRIO (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .r0  (r0_if),
    .r1  (r1_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? r1_if.req_ready : r0_if.req_ready;
  endfunction

  function automatic logic rv(input bit p);
    return p ? r1_if.resp_valid : r0_if.resp_valid;
  endfunction

  function automatic logic rr(input bit p);
    return p ? r1_if.resp_ready : r0_if.resp_ready;
  endfunction

  task automatic drive(input bit p, input logic v, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic is,
                       input logic us);
    if (p) begin
      r1_if.req_valid = v; r1_if.fop = f; r1_if.rs_a = a; r1_if.rs_b = b;
      r1_if.imm = imm; r1_if.imm_sel = is; r1_if.uns = us;
    end else begin
      r0_if.req_valid = v; r0_if.fop = f; r0_if.rs_a = a; r0_if.rs_b = b;
      r0_if.imm = imm; r0_if.imm_sel = is; r0_if.uns = us;
    end
  endtask

  task automatic set_valid(input bit p, input logic v);
    if (p) r1_if.req_valid = v;
    else   r0_if.req_valid = v;
  endtask

  task automatic push(input bit p, input logic [31:0] res, input logic [2:0] fl,
                      input logic err);
    sb_t e;
    e.port = p; e.res = res; e.flags = fl; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (r0_if.resp_valid || r1_if.resp_valid)
        check("resp_exclusive", {31'b0, r0_if.resp_valid & r1_if.resp_valid}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (rv(p[0]) && rr(p[0])) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_unexpected: response on port %0d, expected none", p);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check("resp_port", 32'(p), {31'b0, e.port});
            check("resp_result", r0_if.resp_result, e.res);
            check("resp_flags", {29'b0, r0_if.resp_flags}, {29'b0, e.flags});
            check("resp_err", {31'b0, r0_if.resp_err}, {31'b0, e.err});
          end
        end
      end
    end
  end

  // One isolated request with latency checks; response consumed by the monitor.
  task automatic run_vec(input vec_t v);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(v.port, 1'b1, v.fop, v.a, v.b, v.imm, v.imm_sel, v.uns);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rdy(v.port)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", {31'b0, got}, 32'd1);
    if (got) push(v.port, v.res, v.flags, v.err);
    @(negedge clk);
    set_valid(v.port, 1'b0);
    if (got) begin
      #1;
      check("latency_exec", {31'b0, rv(v.port)}, 32'd0);
      @(negedge clk);
      #1;
      check("latency_resp", {31'b0, rv(v.port)}, 32'd1);
      check("other_no_resp", {31'b0, rv(!v.port)}, 32'd0);
    end
  endtask

  initial begin
    int grants;
    bit gp;
    n_vec  = 0;
    n_miss = 0;

    //            port  fop    a             b             imm           is    us    res           ZNV     err
    vecs[0]  = '{1'b0, ADD,   32'd5,        32'd7,        32'd0,        1'b0, 1'b0, 32'd12,       3'b000, 1'b0};
    vecs[1]  = '{1'b1, SUB,   32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0, 32'h7FFFFFFF, 3'b001, 1'b0};
    vecs[2]  = '{1'b0, SLL,   32'd1,        32'h99,       32'd4,        1'b1, 1'b0, 32'd16,       3'b000, 1'b0};
    vecs[3]  = '{1'b1, IMM,   32'd0,        32'd0,        32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 3'b010, 1'b0};
    vecs[4]  = '{1'b0, 4'd12, 32'h1234,     32'h5678,     32'd0,        1'b0, 1'b0, 32'd0,        3'b100, 1'b1};
    vecs[5]  = '{1'b0, SRA,   32'h80000000, 32'd4,        32'd0,        1'b0, 1'b0, 32'hF8000000, 3'b010, 1'b0};
    vecs[6]  = '{1'b1, SRL,   32'h80000000, 32'd4,        32'd0,        1'b0, 1'b1, 32'h08000000, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, AND,   32'hFF00FF00, 32'h0FF00FF0, 32'd0,        1'b0, 1'b0, 32'h0F000F00, 3'b000, 1'b0};
    vecs[8]  = '{1'b1, OR,    32'hF0,       32'h0F,       32'd0,        1'b0, 1'b0, 32'hFF,       3'b000, 1'b0};
    vecs[9]  = '{1'b0, XOR,   32'h12345678, 32'h12345678, 32'd0,        1'b0, 1'b0, 32'd0,        3'b100, 1'b0};
    vecs[10] = '{1'b0, ADD,   32'h7FFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 32'h80000000, 3'b011, 1'b0};
    vecs[11] = '{1'b1, SUB,   32'd5,        32'd5,        32'd0,        1'b0, 1'b0, 32'd0,        3'b100, 1'b0};
    vecs[12] = '{1'b0, ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 32'd0,        3'b100, 1'b0};
    vecs[13] = '{1'b1, 4'd15, 32'd9,        32'd9,        32'd0,        1'b0, 1'b0, 32'd0,        3'b100, 1'b1};
    vecs[14] = '{1'b0, ADD,   32'd3,        32'd100,      32'hFFFFFFFF, 1'b1, 1'b0, 32'd2,        3'b000, 1'b0};

    // Reset: request present but must not be acknowledged, outputs cleared.
    rst = 1'b1;
    drive(1'b0, 1'b1, ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    r0_if.resp_ready = 1'b1;
    r1_if.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_ready0", {31'b0, r0_if.req_ready}, 32'd0);
    check("rst_resp_valid0", {31'b0, r0_if.resp_valid}, 32'd0);
    check("rst_resp_valid1", {31'b0, r1_if.resp_valid}, 32'd0);
    check("rst_result", r0_if.resp_result, 32'd0);
    check("rst_flags", {29'b0, r0_if.resp_flags}, 32'd0);
    check("rst_err", {31'b0, r0_if.resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_valid(1'b0, 1'b0);

    // Contention right after reset: grants alternate starting with port 0.
    @(negedge clk);
    drive(1'b0, 1'b1, ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, XOR, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0);
    grants = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (r0_if.req_ready || r1_if.req_ready) begin
        check("grant_onehot", {31'b0, r0_if.req_ready & r1_if.req_ready}, 32'd0);
        gp = r1_if.req_ready;
        check("grant_order", {31'b0, gp}, 32'(grants % 2));
        if (gp) push(1'b1, 32'hFF, 3'b000, 1'b0);
        else    push(1'b0, 32'd2, 3'b000, 1'b0);
        grants++;
        if (grants == 6) break;
      end
      @(negedge clk);
    end
    check("grant_count", 32'(grants), 32'd6);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    set_valid(1'b1, 1'b0);
    wait_drain();

    foreach (vecs[i]) run_vec(vecs[i]);
    wait_drain();

    // Backpressure: r0 holds its response while r1 waits.
    @(negedge clk);
    r0_if.resp_ready = 1'b0;
    drive(1'b0, 1'b1, ADD, 32'h11111111, 32'h22222222, 32'd0, 1'b0, 1'b0);
    #1;
    check("bp_accept", {31'b0, r0_if.req_ready}, 32'd1);
    push(1'b0, 32'h33333333, 3'b000, 1'b0);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    drive(1'b1, 1'b1, OR, 32'hA0, 32'h0B, 32'd0, 1'b0, 1'b0);
    #1;
    check("bp_r1_exec_stall", {31'b0, r1_if.req_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_resp_valid", {31'b0, r0_if.resp_valid}, 32'd1);
      check("bp_result_stable", r0_if.resp_result, 32'h33333333);
      check("bp_flags_stable", {29'b0, r0_if.resp_flags}, 32'd0);
      check("bp_r1_stall", {31'b0, r1_if.req_ready}, 32'd0);
      @(negedge clk);
    end
    r0_if.resp_ready = 1'b1;
    #1;
    check("bp_handshake_r1_stall", {31'b0, r1_if.req_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("bp_r1_accept_next", {31'b0, r1_if.req_ready}, 32'd1);
    if (r1_if.req_ready) push(1'b1, 32'hAB, 3'b000, 1'b0);
    @(negedge clk);
    set_valid(1'b1, 1'b0);
    wait_drain();

    // Reset during EXEC: the op vanishes and priority returns to port 0.
    @(negedge clk);
    drive(1'b0, 1'b1, ADD, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0);
    #1;
    check("mid_accept", {31'b0, r0_if.req_ready}, 32'd1);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", {31'b0, r0_if.resp_valid}, 32'd0);
    check("mid_rst_result", r0_if.resp_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mid_no_resp", {30'b0, r1_if.resp_valid, r0_if.resp_valid}, 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, SUB, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, ADD, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0);
    #1;
    check("mid_prio_r0", {31'b0, r0_if.req_ready}, 32'd1);
    check("mid_prio_r1", {31'b0, r1_if.req_ready}, 32'd0);
    if (r0_if.req_ready) push(1'b0, 32'd7, 3'b000, 1'b0);
    if (r1_if.req_ready) push(1'b1, 32'd8, 3'b000, 1'b0);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    set_valid(1'b1, 1'b0);  // r1 retracts without a handshake
    wait_drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
